// File: rtl/i2s_dac_tx.sv
// i2s_dac_tx: mono I2S transmitter for the CS4344 DAC.
// Derives MCLK/SCLK/LRCK from a frame counter and serializes one sample per frame.
module i2s_dac_tx #(
    parameter int MCLK_DIV_LOG2 = 2,
    parameter int REQ_OFFSET    = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] din,
    input  logic        din_valid,
    output logic        sample_req,
    output logic        underrun,
    output logic        mclk,
    output logic        lrck,
    output logic        sclk,
    output logic        sdout
);

    localparam int CW = MCLK_DIV_LOG2 + 9;
    localparam int SL = MCLK_DIV_LOG2 + 3;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [23:0]   hold_q, hold_d;
    logic [23:0]   active_q, active_d;
    logic          fresh_q, fresh_d;
    logic          primed_q, primed_d;
    logic          sample_req_q, sample_req_d;
    logic          underrun_q, underrun_d;
    logic          mclk_q, mclk_d;
    logic          lrck_q, lrck_d;
    logic          sclk_q, sclk_d;
    logic          sdout_q, sdout_d;
    logic          xfer;
    logic [4:0]    slot;
    logic [4:0]    bit_idx;

    // Next-state: frame counter, sample capture/transfer and output decode
    always_comb begin
        cnt_d        = cnt_q + 1'b1;
        xfer         = (cnt_q == {CW{1'b1}});
        hold_d       = din_valid ? din : hold_q;
        fresh_d      = xfer ? 1'b0 : (fresh_q | din_valid);
        active_d     = xfer ? hold_d : active_q;
        primed_d     = xfer ? 1'b1 : primed_q;
        underrun_d   = xfer & ~fresh_q & ~din_valid & primed_q;
        sample_req_d = (cnt_q == CW'(REQ_OFFSET));
        mclk_d       = cnt_q[MCLK_DIV_LOG2-1];
        sclk_d       = cnt_q[MCLK_DIV_LOG2+2];
        lrck_d       = cnt_q[CW-1];
        slot         = cnt_q[CW-2:SL];
        bit_idx      = 5'd24 - slot;
        sdout_d      = 1'b0;
        if (slot >= 5'd1 && slot <= 5'd24) begin
            sdout_d = active_q[bit_idx];
        end
    end

    // State and registered outputs, cleared by synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            hold_q       <= '0;
            active_q     <= '0;
            fresh_q      <= 1'b0;
            primed_q     <= 1'b0;
            sample_req_q <= 1'b0;
            underrun_q   <= 1'b0;
            mclk_q       <= 1'b0;
            lrck_q       <= 1'b0;
            sclk_q       <= 1'b0;
            sdout_q      <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            hold_q       <= hold_d;
            active_q     <= active_d;
            fresh_q      <= fresh_d;
            primed_q     <= primed_d;
            sample_req_q <= sample_req_d;
            underrun_q   <= underrun_d;
            mclk_q       <= mclk_d;
            lrck_q       <= lrck_d;
            sclk_q       <= sclk_d;
            sdout_q      <= sdout_d;
        end
    end

    assign sample_req = sample_req_q;
    assign underrun   = underrun_q;
    assign mclk       = mclk_q;
    assign lrck       = lrck_q;
    assign sclk       = sclk_q;
    assign sdout      = sdout_q;

endmodule

// File: doc/i2s_dac_tx.md
Name: i2s_dac_tx

Overview:
- Downstream stage of the Karplus-Strong voice. Drives the PmodI2S2 DAC (CS4344) on the Nexys3.
- Generates MCLK/LRCK/SCLK from the system clock.
- Issues one `sample_req` pulse per audio frame; this pulse drives the synth's `start` input.
- Captures the returned signed 24-bit sample and serializes it MSB-first in I2S format. The same sample goes to left and right (mono).

Parameters:
- MCLK_DIV_LOG2, 2, log2 of clk cycles per MCLK period (default: MCLK = clk/4 = 25 MHz at 100 MHz); must be ≥1.
- REQ_OFFSET, 0, counter value at which `sample_req` fires; must be < FRAME-1.
- Derived constants, not overridable:
  - CW = MCLK_DIV_LOG2+9
  - FRAME = 2^CW clk cycles per sample (2048 at defaults → Fs = 48.828 kHz)
  - MCLK/Fs = 512; SCLK/Fs = 64

Ports:
- clk  in  1  system clock (100 MHz)
- rst  in  1  synchronous active-high reset
- din  in  24  signed sample from the synth (`dout`)
- din_valid  in  1  din qualifier; sampled every clk
- sample_req  out  1  one-clk pulse requesting the next sample (to the synth's `start`)
- underrun  out  1  one-clk pulse: the frame started without a fresh sample
- mclk  out  1  DAC master clock
- lrck  out  1  word select; 0 = left, 1 = right
- sclk  out  1  serial bit clock
- sdout  out  1  serial data

Behaviour:
- Free-running counter `cnt[CW-1:0]`; +1 per clk, wraps FRAME-1→0. Reset sets cnt=0.
- All outputs are registered. Clock outputs are decoded from cnt and change together on the clk edge after cnt reaches the decoding value:
  - mclk = cnt[MCLK_DIV_LOG2-1]
  - sclk = cnt[MCLK_DIV_LOG2+2]
  - lrck = cnt[CW-1]
- Defaults:
  - mclk period 4 clk, 50% duty.
  - sclk period 32 clk; falls at each 32-clk slot boundary.
  - lrck period 2048 clk; changes coincident with an sclk falling edge.
- Slots: 32 sclk slots per channel, index k = cnt[CW-2:MCLK_DIV_LOG2+3].
  - k=0: sdout=0 (I2S one-bit delay).
  - k=1..24: sdout = active[24-k], MSB first.
  - k=25..31: sdout=0.
- sdout changes only on the same clk edge as an sclk falling edge; it is stable through each sclk rise.
- Request/capture:
  - sample_req=1 for exactly the clk where cnt==REQ_OFFSET (and rst=0).
  - On any clk with din_valid=1, hold←din and fresh←1. The last valid in a frame wins. din_valid may be a pulse or a multi-cycle level; each high cycle recaptures.
- Frame transfer at cnt==FRAME-1:
  - active←hold; fresh←0.
  - If fresh was 0, underrun pulses 1 clk at that cycle and active keeps the previous hold (sample repeats).
  - If din_valid is high on the transfer cycle, the transfer uses the new din and that capture counts as fresh.
- Latency: a sample requested in frame N plays in both channels of frame N+1.
- Reset (sync, any time, including mid-frame):
  - cnt, hold, active, fresh ← 0.
  - mclk, lrck, sclk, sdout, sample_req, underrun = 0 on the clk after rst is sampled high; they stay 0 while rst=1.
  - After release, cnt counts from 0.
  - sample_req for REQ_OFFSET=0 fires on the first clk with rst=0.
  - The first frame outputs zeros; no underrun is flagged for the first transfer after reset.
- Arithmetic: din is treated as raw bits; no rescaling or sign extension (two's complement MSB sent first).

Test Plan:
- Reset release, no din_valid → sample_req every 2048 clk. mclk period 4, sclk period 32, lrck period 2048 (duty 50%). sdout all 0. underrun first pulses at the second transfer (cnt==2047 of frame 1).
- Return din=24'h800001 on din_valid 10 clk after each sample_req → next frame, left and right each shift 0,1,0×22,1,0×7 on sclk rising edges. No underrun.
- Drive din=24'h123456 then 24'hABCDEF with two valids in the same frame → next frame serializes 24'hABCDEF.
- Supply 24'h7FFFFF once, then stop → following frames repeat 24'h7FFFFF. underrun pulses once per frame.
- Assert rst for 3 clk mid-frame (cnt=700) → all outputs 0 the next clk. cnt restarts. sample_req appears on the first clk after release. Prior hold is discarded (frame outputs 0).
- Hook to karplus_strong (length=183, newnote pulse): sample_req→start, dout→din. Dump 24000 played samples and check the bit-exact match against the synth's dout stream, delayed by one frame.
